// File: rtl/demoscene_engine.sv
// Demo tile top: VGA timing and pattern generator, SPI register bank, square-wave synth with PWM audio out.
// Latency: video outputs 1 cycle after counter state; SPI writes land 1 cycle after the 16th synchronised SCLK rise.
// Backpressure: none; free-running pixel pipeline, and SPI is paced by the external master (SCLK <= clk/8).
module demoscene_engine #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int COLOR_BITS    = 2,
    parameter int AUDIO_CH      = 2,
    parameter int PWM_BITS      = 8,
    parameter int TONE_PRESCALE = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  SSEL,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [COLOR_BITS-1:0] vga_r,
    output logic [COLOR_BITS-1:0] vga_g,
    output logic [COLOR_BITS-1:0] vga_b,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  pwm_out
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DIVW     = $clog2(256 * TONE_PRESCALE);
    localparam int VOL      = (2**PWM_BITS - 1) / AUDIO_CH;

    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic [11:0]   frame;
    logic [3:0]    ctrl;
    logic [7:0]    scroll;
    logic [7:0]    tone [AUDIO_CH];

    // ---------------- timing ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos <= '0;
            vpos <= '0;
        end else if (int'(hpos) == H_TOTAL - 1) begin
            hpos <= '0;
            vpos <= (int'(vpos) == V_TOTAL - 1) ? '0 : vpos + 1'b1;
        end else begin
            hpos <= hpos + 1'b1;
        end
    end

    logic [11:0] h12, v12, p;
    logic        display_on, hs_n, vs_n, frame_upd;
    logic        p_unused;

    always_comb begin
        h12 = 12'(hpos);
        v12 = 12'(vpos);
        case (ctrl[3:2])
            2'd0:    p = (h12 ^ v12) + frame;
            2'd1:    p = h12 + frame;
            2'd2:    p = v12 + frame;
            default: p = {h12[5] ^ v12[5], 11'b0} + frame;
        endcase
        display_on = (int'(hpos) < H_ACTIVE) && (int'(vpos) < V_ACTIVE);
        hs_n       = !((int'(hpos) >= HS_START) && (int'(hpos) < HS_END));
        vs_n       = !((int'(vpos) >= VS_START) && (int'(vpos) < VS_END));
        frame_upd  = (hpos == '0) && (int'(vpos) == VS_START);
    end
    assign p_unused = ^p;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            // scroll is sampled here before any same-cycle SPI write lands
            if (frame_upd)
                frame <= frame + 12'(scroll);
            hsync <= hs_n;
            vsync <= vs_n;
            if (display_on && ctrl[0]) begin
                vga_r <= p[2 +: COLOR_BITS];
                vga_g <= p[2 + COLOR_BITS +: COLOR_BITS];
                vga_b <= p[2 + 2*COLOR_BITS +: COLOR_BITS];
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

    // ---------------- SPI slave ----------------
    logic [1:0]  sclk_s, ssel_s, mosi_s;
    logic        sclk_q, rise, fall, selected;
    logic [3:0]  bit_cnt;
    logic [14:0] shift_in;
    logic [7:0]  shift_out;
    logic        rd_active;
    logic [15:0] word;
    logic [7:0]  hdr, rd_val;
    logic        wr_en;
    logic [AUDIO_CH-1:0] tone_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s <= 2'b00;
            ssel_s <= 2'b11;
            mosi_s <= 2'b00;
            sclk_q <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[0], SCLK};
            ssel_s <= {ssel_s[0], SSEL};
            mosi_s <= {mosi_s[0], MOSI};
            sclk_q <= sclk_s[1];
        end
    end

    always_comb begin
        rise     = sclk_s[1] & ~sclk_q;
        fall     = ~sclk_s[1] & sclk_q;
        selected = ~ssel_s[1];
        word     = {shift_in, mosi_s[1]};
        hdr      = {shift_in[6:0], mosi_s[1]};
        wr_en    = rise && selected && (bit_cnt == 4'd15) && word[15];
        rd_val   = 8'h00;
        if (hdr[6:0] == 7'd0)
            rd_val = {4'b0, ctrl};
        else if (hdr[6:0] == 7'd1)
            rd_val = scroll;
        for (int c = 0; c < AUDIO_CH; c++) begin
            if (hdr[6:0] == 7'(2 + c))
                rd_val = tone[c];
            tone_wr[c] = wr_en && (word[14:8] == 7'(2 + c));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            rd_active <= 1'b0;
            MISO      <= 1'b0;
        end else if (!selected) begin
            bit_cnt   <= '0;
            rd_active <= 1'b0;
            MISO      <= 1'b0;
        end else if (rise) begin
            shift_in <= word[14:0];
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7 && !hdr[7]) begin
                shift_out <= rd_val;
                rd_active <= 1'b1;
            end
            if (bit_cnt == 4'd15) begin
                rd_active <= 1'b0;
                MISO      <= 1'b0;
            end
        end else if (fall && rd_active) begin
            MISO      <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl   <= 4'b0001;
            scroll <= '0;
            for (int c = 0; c < AUDIO_CH; c++)
                tone[c] <= '0;
        end else if (wr_en) begin
            if (word[14:8] == 7'd0)
                ctrl <= word[3:0];
            if (word[14:8] == 7'd1)
                scroll <= word[7:0];
            for (int c = 0; c < AUDIO_CH; c++)
                if (tone_wr[c])
                    tone[c] <= word[7:0];
        end
    end

    // ---------------- tone synth, mixer, PWM ----------------
    logic [DIVW-1:0]     div     [AUDIO_CH];
    logic [DIVW-1:0]     div_lim [AUDIO_CH];
    logic [AUDIO_CH-1:0] sq;
    logic [2:0]          n_high;
    logic [PWM_BITS-1:0] sample, pwm_cnt, duty;

    always_comb begin
        n_high = '0;
        for (int c = 0; c < AUDIO_CH; c++) begin
            div_lim[c] = DIVW'((int'(tone[c]) + 1) * TONE_PRESCALE - 1);
            n_high     = n_high + 3'(sq[c]);
        end
        sample = ctrl[1] ? PWM_BITS'(VOL * int'(n_high)) : '0;
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < AUDIO_CH; c++) begin
            if (reset) begin
                div[c] <= '0;
                sq[c]  <= 1'b0;
            end else if (tone_wr[c]) begin
                div[c] <= '0;
            end else if (tone[c] == 8'd0) begin
                div[c] <= '0;
                sq[c]  <= 1'b0;
            end else if (div[c] == div_lim[c]) begin
                div[c] <= '0;
                sq[c]  <= ~sq[c];
            end else begin
                div[c] <= div[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1)
                duty <= sample;
            pwm_out <= (pwm_cnt < duty);
        end
    end
endmodule

// File: tb/tb_demoscene_engine.sv
// Bench for demoscene_engine on a shrunk 24x12 raster: frame-level video model, SPI transactions, PWM window counts.
module tb_demoscene_engine;
    localparam int HA = 16, HFP = 2, HS = 4, HBP = 2;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 1;
    localparam int CB = 2, AC = 2, PB = 8, PRE = 4;
    localparam int HT = HA + HFP + HS + HBP;   // 24
    localparam int VT = VA + VFP + VS + VBP;   // 12
    localparam int FT = HT * VT;               // 288
    localparam int UPD = (VA + VFP) * HT;      // frame-update point within a frame

    logic clk = 1'b0, reset = 1'b1, SCLK = 1'b0, SSEL = 1'b1, MOSI = 1'b0;
    logic MISO, hsync, vsync, pwm_out;
    logic [CB-1:0] vga_r, vga_g, vga_b;

    demoscene_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .COLOR_BITS(CB), .AUDIO_CH(AC), .PWM_BITS(PB), .TONE_PRESCALE(PRE)
    ) dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- video model: raster position from elapsed cycles, frame accumulated from SCROLL ----
    int n = 0, mframe = 0, upd_count = 0, out_h = -1, out_v = -1;
    int e_hs = 1, e_vs = 1, e_r = 0, e_g = 0, e_b = 0;
    logic [3:0] m_ctrl = 4'h1;
    logic [7:0] m_scroll = 8'h00;
    bit chk_video = 1'b0;

    initial forever begin
        int h, v, p;
        @(posedge clk);
        if (reset) begin
            n = 0; mframe = 0; out_h = -1; out_v = -1;
            e_hs = 1; e_vs = 1; e_r = 0; e_g = 0; e_b = 0;
        end else begin
            h = n % HT;
            v = (n / HT) % VT;
            e_hs = (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
            e_vs = (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
            case (m_ctrl[3:2])
                2'd0: p = (h ^ v) + mframe;
                2'd1: p = h + mframe;
                2'd2: p = v + mframe;
                default: p = ((((h >> 5) ^ (v >> 5)) & 1) << 11) + mframe;
            endcase
            p = p % 4096;
            if (h < HA && v < VA && m_ctrl[0]) begin
                e_r = (p >> 2) % (1 << CB);
                e_g = (p >> (2 + CB)) % (1 << CB);
                e_b = (p >> (2 + 2*CB)) % (1 << CB);
            end else begin
                e_r = 0; e_g = 0; e_b = 0;
            end
            out_h = h; out_v = v;
            if (h == 0 && v == VA + VFP) begin
                mframe = (mframe + m_scroll) % 4096;
                upd_count++;
            end
            n++;
        end
    end

    initial forever begin
        int act, exp;
        @(negedge clk);
        if (chk_video) begin
            act = ((((hsync ? 1 : 0) * 2 + (vsync ? 1 : 0)) << (3*CB)) |
                   (int'(vga_r) << (2*CB)) | (int'(vga_g) << CB) | int'(vga_b));
            exp = (((e_hs * 2 + e_vs) << (3*CB)) | (e_r << (2*CB)) | (e_g << CB) | e_b);
            check("video_cycle", act, exp);
        end
    end

    // ---- SPI master (SCLK = clk/8) ----
    task automatic spi_xfer(input logic [15:0] w, input int nbits, output logic [7:0] rd);
        rd = 8'h00;
        @(negedge clk); SSEL = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[15-i];
            repeat (4) @(negedge clk);
            SCLK = 1'b1;
            if (i >= 8) rd[15-i] = MISO;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (4) @(negedge clk);
        SSEL = 1'b1; MOSI = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_read(input logic [6:0] a, output logic [7:0] d);
        spi_xfer({1'b0, a, 8'h00}, 16, d);
    endtask

    // keep register writes clear of the frame update so the model's SCROLL tracks the DUT's
    task automatic wait_safe();
        for (int i = 0; i < FT + 4; i++) begin
            if (n % FT == UPD + 1) break;
            @(negedge clk);
        end
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        wait_safe();
        chk_video = 1'b0;
        spi_xfer({1'b1, a, d}, 16, dummy);
        if (a == 7'd0) m_ctrl = d[3:0];
        if (a == 7'd1) m_scroll = d;
        chk_video = 1'b1;
    endtask

    // ---- PWM window measurement, windows aligned to the free-running PWM counter ----
    int win_cnt[4], win_early[4];

    task automatic pwm_windows(input int nw);
        for (int w = 0; w < 4; w++) begin win_cnt[w] = 0; win_early[w] = 0; end
        for (int i = 0; i < 300; i++) begin
            if (n % 256 == 1) break;
            @(negedge clk);
        end
        for (int w = 0; w < nw; w++)
            for (int o = 0; o < 256; o++) begin
                if (pwm_out) begin
                    win_cnt[w]++;
                    if (o < 127) win_early[w]++;
                end
                @(negedge clk);
            end
    endtask

    int hs_f1 = -1, hs_f2 = -1, hs_low = 0, vs_f1 = -1, vs_f2 = -1, vs_low = 0;
    bit hs_p = 1'b1, vs_p = 1'b1;
    logic [7:0] rd;
    int cnt, u0;
    bit found;
    logic [15:0] wmid;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_hsync", hsync, 1);
        check("reset_vsync", vsync, 1);
        check("reset_rgb", int'({vga_r, vga_g, vga_b}), 0);
        check("reset_pwm", pwm_out, 0);
        check("reset_miso", MISO, 0);
        reset = 1'b0;
        chk_video = 1'b1;

        // sync timing and a few pixels pinned by hand
        for (int k = 1; k <= 520; k++) begin
            @(negedge clk);
            if (!hsync && hs_p) begin if (hs_f1 < 0) hs_f1 = k; else if (hs_f2 < 0) hs_f2 = k; end
            if (!vsync && vs_p) begin if (vs_f1 < 0) vs_f1 = k; else if (vs_f2 < 0) vs_f2 = k; end
            if (k <= HT && !hsync) hs_low++;
            if (k <= FT && !vsync) vs_low++;
            if (k == 5) begin
                check("pix_h4_r", vga_r, 1);
                check("pix_h4_g", vga_g, 0);
                check("pix_h4_b", vga_b, 0);
            end
            if (k == 17) check("blank_h16_rgb", int'({vga_r, vga_g, vga_b}), 0);
            hs_p = hsync; vs_p = vsync;
        end
        check("hsync_first_fall", hs_f1, 19);
        check("hsync_low_width", hs_low, 4);
        check("line_period", hs_f2 - hs_f1, 24);
        check("vsync_first_fall", vs_f1, 217);
        check("vsync_low_cycles", vs_low, 48);
        check("frame_period", vs_f2 - vs_f1, 288);

        // reads
        spi_read(7'h00, rd); check("read_ctrl_reset", rd, 8'h01);
        spi_read(7'h7F, rd); check("read_invalid", rd, 8'h00);
        spi_read(7'h01, rd); check("read_scroll_reset", rd, 8'h00);

        // aborted write of CTRL<-0x00 after 10 bits
        spi_xfer(16'h0000 | 16'h8000, 10, rd);
        repeat (20) @(negedge clk);
        spi_read(7'h00, rd); check("abort_ctrl", rd, 8'h01);

        // pattern 1 then SCROLL=5
        spi_write(7'h00, 8'h05);
        spi_read(7'h00, rd); check("read_ctrl_05", rd, 8'h05);
        spi_write(7'h01, 8'h05);
        u0 = upd_count;
        found = 1'b0;
        for (int i = 0; i < 2*FT; i++) begin
            if (out_v == 0 && out_h == 3 && upd_count > u0) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("scroll_wait", found, 1);
        check("model_frame", mframe, 5);
        check("scroll_h3_r", vga_r, 2);
        check("scroll_h3_g", vga_g, 0);
        check("scroll_h3_b", vga_b, 0);

        // audio
        cnt = 0;
        for (int i = 0; i < 600; i++) begin @(negedge clk); if (pwm_out) cnt++; end
        check("pwm_audio_off", cnt, 0);
        spi_write(7'h03, 8'h3F);
        spi_write(7'h00, 8'h03);
        pwm_windows(2);
        pwm_windows(4);
        for (int w = 0; w < 4; w++) begin
            check("pwm_win_level", (win_cnt[w] == 0 || win_cnt[w] == 127) ? 1 : 0, 1);
            check("pwm_win_front", win_early[w], win_cnt[w]);
        end
        for (int w = 0; w < 3; w++)
            check("pwm_win_alternate", win_cnt[w] + win_cnt[w+1], 127);
        spi_write(7'h03, 8'h00);
        pwm_windows(2);
        pwm_windows(2);
        check("pwm_tone_zero", win_cnt[0] + win_cnt[1], 0);

        // reset during bit 12 of SCROLL<-0x09
        wmid = {1'b1, 7'h01, 8'h09};
        wait_safe();
        chk_video = 1'b0;
        @(negedge clk); SSEL = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            MOSI = wmid[15-i];
            repeat (4) @(negedge clk);
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
        end
        MOSI = wmid[4];
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_hsync", hsync, 1);
        check("midrst_vsync", vsync, 1);
        check("midrst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        check("midrst_pwm", pwm_out, 0);
        check("midrst_miso", MISO, 0);
        reset = 1'b0; SSEL = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        m_ctrl = 4'h1; m_scroll = 8'h00;
        chk_video = 1'b1;
        repeat (10) @(negedge clk);
        spi_read(7'h01, rd); check("midrst_scroll", rd, 8'h00);
        spi_read(7'h00, rd); check("midrst_ctrl", rd, 8'h01);
        spi_read(7'h03, rd); check("midrst_tone1", rd, 8'h00);
        repeat (50) @(negedge clk);
        chk_video = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/demoscene_engine.md
# demoscene_engine

Parametrised successor to the demoscene top level. Integrates configurable VGA timing, a pattern-based pixel generator, an SPI-slave register bank and a multi-channel square-wave synthesiser mixed into one PWM audio output. Sits directly under the tile top. Timing and colour depth are parameters; behaviour is runtime-controlled over SPI.

## Interface

Parameters:

- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- COLOR_BITS, 2, bits per colour channel; legal range 1..3
- AUDIO_CH, 2, tone channels; legal range 1..4
- PWM_BITS, 8, PWM resolution
- TONE_PRESCALE, 64, clocks per tone-period unit

Ports:

- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- SCLK  in  1  SPI clock (mode 0), asynchronous
- SSEL  in  1  SPI select, active-low, asynchronous
- MOSI  in  1  SPI data in
- MISO  out  1  SPI data out
- vga_r / vga_g / vga_b  out  COLOR_BITS  colour
- hsync / vsync  out  1  active-low syncs
- pwm_out  out  1  audio PWM

## Operation

- **Timing.**
  - hpos runs 0..H_TOTAL-1 and wraps to 0. At each hpos wrap, vpos increments, wrapping at V_TOTAL-1.
  - hsync is low for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on vpos.
  - display_on = hpos<H_ACTIVE && vpos<V_ACTIVE.
- **Frame counter.**
  - 12-bit frame counter; frame += SCROLL (mod 4096) on the cycle where hpos==0 and vpos==V_ACTIVE+V_FP.
- **Pattern value p (12-bit, mod 4096), selected by CTRL[3:2]:**
  - 0: (hpos^vpos)+frame
  - 1: hpos+frame
  - 2: vpos+frame
  - 3: {hpos[5]^vpos[5], 11'b0}+frame
- **Colour mapping.**
  - R=p[2 +: COLOR_BITS], G=p[2+COLOR_BITS +: COLOR_BITS], B=p[2+2*COLOR_BITS +: COLOR_BITS].
  - Colour is forced to 0 when !display_on or CTRL[0]==0.
- **SPI input path.**
  - SCLK, SSEL and MOSI each pass through a 2-flop synchroniser, then rising/falling edge detect on synchronised SCLK.
- **SPI frame.** 16 bits, MSB first, sampled on SCLK rise:
  - bit15: 1=write, 0=read
  - bits14:8: address
  - bits7:0: write data
- **Write commit.** On the 16th rise, if still selected and the address is valid, the register is written.
- **Frame abort.** SSEL deassert mid-frame resets the bit counter; no write occurs. Invalid address: write ignored, read returns 0x00.
- **Read data.** On a read, the addressed register is loaded into the shift-out register after the 8th rise. MISO presents its MSB by the next SCLK fall and shifts on each subsequent fall. MISO=0 otherwise.
- **Registers:**
  - 0x00 CTRL: bit0 video_en, bit1 audio_en, bits3:2 pattern, bits7:4 read as 0. Reset value 0x01.
  - 0x01 SCROLL. Reset value 0x00.
  - 0x02+c (c<AUDIO_CH): TONE[c]. Reset value 0x00.
- **Tone channels.**
  - Channel c toggles its square output every (TONE[c]+1)*TONE_PRESCALE clocks.
  - TONE[c]==0 holds the channel output low and its divider cleared.
  - A write to TONE[c] restarts that divider.
- **Mixer.**
  - VOL = floor((2^PWM_BITS-1)/AUDIO_CH).
  - sample = VOL × (number of channels high); the sum never overflows PWM_BITS.
  - sample is forced to 0 when CTRL[1]==0.
- **PWM.**
  - PWM_BITS counter free-runs 0..2^PWM_BITS-1.
  - sample is latched into duty only when the counter wraps to 0.
  - pwm_out = (counter < duty), registered.

## Timing

- **Reset values:**
  - hpos, vpos, frame, all dividers, the PWM counter and duty = 0
  - hsync=1, vsync=1, vga_*=0, pwm_out=0, MISO=0
  - CTRL=0x01, SCROLL=0, TONE=0
- **Video pipeline.** All video outputs are registered with exactly 1 cycle from counter state. Sync and colour stay mutually aligned.
- **SPI latency.** SPI edge detection lags the pins by 3 clk cycles. A write takes effect 1 cycle after the 16th detected rise.
- **Register write timing.**
  - A CTRL write takes effect on the next pixel.
  - A SCROLL write takes effect at the next frame update.
- **SCLK limit.** SCLK must be ≤ clk/8; faster SCLK is unsupported.
- **Reset mid-operation.** Reset asserted mid-frame or mid-SPI transaction returns every item listed above to its reset value on the next edge. Any partial SPI frame is discarded.
- **Wrap and simultaneous events.**
  - hpos wrap on the last line wraps vpos in the same cycle.
  - A SCROLL write coinciding with the frame update: the frame uses the old SCROLL.

## Test plan

- **Reset/sync timing:** release reset, default params → first hsync fall after 656 cycles, low 96 cycles; vsync low on lines 490–491; line period 800, frame period 525×800.
- **Pattern 1, SCROLL=0:** hpos=4,vpos=0 → p=4, R=1,G=0,B=0 with COLOR_BITS=2. Blanking region → all colours 0.
- **SPI write/read:**
  - write 0x01←0x05 → after one vsync, frame=5.
  - read 0x00 → MISO shifts 0x01 (MSB first).
  - read 0x7F → 0x00.
- **Abort:** raise SSEL after 10 bits of write 0x00←0x00 → CTRL stays 0x01, video remains on.
- **Audio:**
  - CTRL=0x03, TONE[0]=0x00, TONE[1]=0x01, PRESCALE=64 → channel 1 toggles every 128 clocks.
  - duty alternates 0 and 127; pwm_out high 127 of 256 cycles while channel 1 high, 0 otherwise.
- **Reset mid-transaction:** assert reset during bit 12 of a write → no register change; all outputs at reset values next cycle.
